// File: rtl/e_counter_monitor_pkg.sv
// Shared definitions for the two-phase counter monitor: FSM state encoding,
// expected-pair update commands and the status word bit layout.
package e_counter_monitor_pkg;

  // Monitor FSM states; code 3 is never entered and behaves like SYNC.
  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_RUN_X  = 2'd1,
    ST_RUN_Y  = 2'd2,
    ST_UNUSED = 2'd3
  } mon_state_e;

  // Commands from the FSM to the expected-pair tracker.
  typedef enum logic [2:0] {
    EXP_HOLD       = 3'd0,
    EXP_SET_10     = 3'd1,
    EXP_INC_X      = 3'd2,
    EXP_SET_XMAX_1 = 3'd3,
    EXP_INC_Y      = 3'd4,
    EXP_SET_00     = 3'd5
  } exp_cmd_e;

  // Status word field positions.
  localparam int OUT_STATE_HI    = 15;
  localparam int OUT_STATE_LO    = 14;
  localparam int OUT_ERR_BIT     = 13;
  localparam int OUT_MISMATCH_BIT = 12;
  localparam int OUT_WRAP_BIT    = 11;
  localparam int OUT_PERIODS_HI  = 7;
  localparam int OUT_PERIODS_LO  = 0;

  // Build the status word; bits 10:8 are always zero.
  function automatic logic [15:0] pack_status(input mon_state_e st,
                                              input logic       err,
                                              input logic       mis,
                                              input logic       wrap,
                                              input logic [7:0] periods);
    logic [15:0] s;
    s = '0;
    s[OUT_STATE_HI:OUT_STATE_LO]     = st;
    s[OUT_ERR_BIT]                   = err;
    s[OUT_MISMATCH_BIT]              = mis;
    s[OUT_WRAP_BIT]                  = wrap;
    s[OUT_PERIODS_HI:OUT_PERIODS_LO] = periods;
    return s;
  endfunction

endpackage

// File: rtl/e_counter_monitor_if.sv
// Bus between the observed counter stream and the monitor.
// Stream semantics: there is no valid/ready; input__ carries one {x,y} pair
// every clock and is always considered valid, clr_i is a level sampled on the
// same edge, and output__ is a registered status word updated every edge.
interface e_counter_monitor_if;
  logic [15:0] input__;
  logic        clr_i;
  logic [15:0] output__;

  modport master (output input__, output clr_i, input output__);
  modport slave  (input input__, input clr_i, output output__);
endinterface

// File: rtl/e_pair_expect.sv
// Expected-pair tracker: holds the {x,y} pair expected on the next edge,
// compares it with the observed pair and applies FSM update commands.
module e_pair_expect
  import e_counter_monitor_pkg::*;
#(
  parameter int X_MAX = 8,
  parameter int Y_MAX = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  exp_cmd_e   i_cmd,
  output logic       o_match,
  output logic       o_x_at_max,
  output logic       o_y_at_max
);

  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [7:0] YM = 8'(Y_MAX);

  logic [7:0] r_exp_x;
  logic [7:0] r_exp_y;

  assign o_match    = (i_x == r_exp_x) && (i_y == r_exp_y);
  assign o_x_at_max = (r_exp_x == XM);
  assign o_y_at_max = (r_exp_y == YM);

  // Update the expected pair; the FSM only issues increments below the bounds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exp_x <= 8'd0;
      r_exp_y <= 8'd0;
    end else begin
      case (i_cmd)
        EXP_SET_10: begin
          r_exp_x <= 8'd1;
          r_exp_y <= 8'd0;
        end
        EXP_INC_X:  r_exp_x <= r_exp_x + 8'd1;
        EXP_SET_XMAX_1: begin
          r_exp_x <= XM;
          r_exp_y <= 8'd1;
        end
        EXP_INC_Y:  r_exp_y <= r_exp_y + 8'd1;
        EXP_SET_00: begin
          r_exp_x <= 8'd0;
          r_exp_y <= 8'd0;
        end
        default: begin
          r_exp_x <= r_exp_x;
          r_exp_y <= r_exp_y;
        end
      endcase
    end
  end

endmodule

// File: rtl/e_counter_monitor.sv
// Monitor for a two-phase feedback counter: locks onto (0,0), follows the
// legal x-then-y period, flags deviations and counts completed periods.
module e_counter_monitor
  import e_counter_monitor_pkg::*;
#(
  parameter int X_MAX = 8,
  parameter int Y_MAX = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  e_counter_monitor_if.slave   mon_bus
);

  mon_state_e r_state;
  mon_state_e w_state_next;
  logic       r_done;
  logic       w_done_next;
  logic       r_mismatch;
  logic       w_mismatch_next;
  logic       r_wrap;
  logic       w_wrap_next;
  logic       r_err_sticky;
  logic [7:0] r_periods;
  exp_cmd_e   w_cmd;

  logic [7:0] w_in_x;
  logic [7:0] w_in_y;
  logic       w_in_zero;
  logic       w_match;
  logic       w_x_at_max;
  logic       w_y_at_max;

  assign w_in_x    = mon_bus.input__[15:8];
  assign w_in_y    = mon_bus.input__[7:0];
  assign w_in_zero = (mon_bus.input__ == 16'h0000);

  e_pair_expect #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_pair_expect (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_x        (w_in_x),
    .i_y        (w_in_y),
    .i_cmd      (w_cmd),
    .o_match    (w_match),
    .o_x_at_max (w_x_at_max),
    .o_y_at_max (w_y_at_max)
  );

  // Next-state, expected-pair command and pulse decisions.
  always_comb begin
    w_state_next    = r_state;
    w_cmd           = EXP_HOLD;
    w_done_next     = r_done;
    w_mismatch_next = 1'b0;
    w_wrap_next     = 1'b0;
    case (r_state)
      ST_RUN_X, ST_RUN_Y: begin
        if (!w_match) begin
          // Deviation: flag it; a (0,0) restarts tracking at once, without a wrap.
          w_mismatch_next = 1'b1;
          w_done_next     = 1'b0;
          if (w_in_zero) begin
            w_state_next = ST_RUN_X;
            w_cmd        = EXP_SET_10;
          end else begin
            w_state_next = ST_SYNC;
          end
        end else if (r_state == ST_RUN_X) begin
          if (w_x_at_max) begin
            w_state_next = ST_RUN_Y;
            w_cmd        = EXP_SET_XMAX_1;
          end else begin
            // exp (0,0) increments to (1,0) like any other x step.
            w_cmd = EXP_INC_X;
            if (w_in_zero && r_done) begin
              w_wrap_next = 1'b1;
              w_done_next = 1'b0;
            end
          end
        end else begin
          if (w_y_at_max) begin
            w_state_next = ST_RUN_X;
            w_cmd        = EXP_SET_00;
            w_done_next  = 1'b1;
          end else begin
            w_cmd = EXP_INC_Y;
          end
        end
      end
      default: begin
        // SYNC (and unused code 3): wait silently for (0,0).
        w_done_next = 1'b0;
        if (w_in_zero) begin
          w_state_next = ST_RUN_X;
          w_cmd        = EXP_SET_10;
        end else begin
          w_state_next = ST_SYNC;
        end
      end
    endcase
  end

  // State, pulses, sticky error and saturating period count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_SYNC;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_sticky <= 1'b0;
      r_periods    <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_done     <= w_done_next;
      r_mismatch <= w_mismatch_next;
      r_wrap     <= w_wrap_next;
      // A new mismatch outranks a clear on the sticky flag.
      if (w_mismatch_next) begin
        r_err_sticky <= 1'b1;
      end else if (mon_bus.clr_i) begin
        r_err_sticky <= 1'b0;
      end
      // A clear outranks a wrap on the period count.
      if (mon_bus.clr_i) begin
        r_periods <= 8'd0;
      end else if (w_wrap_next && (r_periods != 8'hFF)) begin
        r_periods <= r_periods + 8'd1;
      end
    end
  end

  assign mon_bus.output__ = pack_status(r_state, r_err_sticky, r_mismatch,
                                        r_wrap, r_periods);

endmodule

// File: tb/tb_e_counter_monitor.sv
// Directed bench for e_counter_monitor with default X_MAX=8, Y_MAX=6
// (legal period of 15 pairs).
module tb_e_counter_monitor;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic any_mis;

  e_counter_monitor_if bus ();

  e_counter_monitor #(
    .X_MAX (8),
    .Y_MAX (6)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .mon_bus (bus)
  );

  // Clock and initial reset level.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // k-th pair of the legal period for X_MAX=8, Y_MAX=6.
  function automatic logic [15:0] legal_pair(input int k);
    logic [7:0] y;
    if (k == 0) return 16'h0000;
    if (k <= 8) return {8'(k), 8'h00};
    y = 8'(k - 8);
    return {8'd8, y};
  endfunction

  // Drive one pair on the falling edge; return just after the rising edge.
  task automatic apply(input logic [15:0] pair, input logic clr);
    @(negedge clk);
    bus.input__ = pair;
    bus.clr_i   = clr;
    @(posedge clk);
    #1;
    if (bus.output__[12]) any_mis = 1'b1;
  endtask

  task automatic run_periods(input int n);
    for (int p = 0; p < n; p++)
      for (int k = 0; k < 15; k++)
        apply(legal_pair(k), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.input__ = 16'h1234;
    bus.clr_i   = 1'b0;
    #1;
    check_eq("reset_out", bus.output__, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    any_mis     = 1'b0;
    rst         = 1'b1;
    bus.input__ = 16'h0000;
    bus.clr_i   = 1'b0;

    // One legal period plus the next (0,0): single wrap, periods=1.
    do_reset();
    apply(legal_pair(0), 1'b0);
    check_eq("first_zero", bus.output__, 16'h4000);
    for (int k = 1; k <= 8; k++) apply(legal_pair(k), 1'b0);
    check_eq("enter_run_y", bus.output__, 16'h8000);
    for (int k = 9; k <= 14; k++) apply(legal_pair(k), 1'b0);
    check_eq("end_run_y", bus.output__, 16'h4000);
    apply(legal_pair(0), 1'b0);
    check_eq("first_wrap", bus.output__, 16'h4801);
    apply(legal_pair(1), 1'b0);
    check_eq("wrap_pulse_end", bus.output__, 16'h4001);
    check_eq("no_mis_legal", {15'd0, any_mis}, 16'h0000);

    // 17 periods, one more wrap, then a clear.
    do_reset();
    run_periods(17);
    apply(16'h0000, 1'b0);
    check_eq("periods_17", bus.output__, 16'h4811);
    apply(16'h0100, 1'b1);
    check_eq("clr_periods", bus.output__, 16'h4000);

    // Skip in RUN_X: (5,0) instead of (4,0).
    apply(16'h0200, 1'b0);
    apply(16'h0300, 1'b0);
    apply(16'h0500, 1'b0);
    check_eq("x_skip_mis", bus.output__, 16'h3000);
    apply(16'h0700, 1'b0);
    check_eq("sync_silent", bus.output__, 16'h2000);
    apply(16'h0000, 1'b0);
    check_eq("sync_lock", bus.output__, 16'h6000);
    apply(16'h0100, 1'b0);
    apply(16'h0200, 1'b1);
    check_eq("clr_err", bus.output__, 16'h4000);

    // (0,0) in RUN_Y at exp (8,3): mismatch, immediate resync, no wrap.
    for (int k = 3; k <= 10; k++) apply(legal_pair(k), 1'b0);
    check_eq("at_8_2", bus.output__, 16'h8000);
    apply(16'h0000, 1'b0);
    check_eq("y_zero_resync", bus.output__, 16'h7000);
    apply(16'h0100, 1'b0);
    check_eq("resync_accept", bus.output__, 16'h6000);
    for (int k = 2; k <= 14; k++) apply(legal_pair(k), 1'b0);
    apply(16'h0000, 1'b0);
    check_eq("wrap_after_resync", bus.output__, 16'h6801);

    // Clear together with a mismatch: error kept, periods cleared.
    apply(16'h0500, 1'b1);
    check_eq("clr_with_mis", bus.output__, 16'h3000);

    // Clear together with a wrap: wrap pulses, count cleared.
    do_reset();
    run_periods(2);
    apply(16'h0000, 1'b1);
    check_eq("clr_with_wrap", bus.output__, 16'h4800);
    apply(16'h0100, 1'b0);
    check_eq("after_clr_wrap", bus.output__, 16'h4000);

    // 300 periods: count saturates, no mismatch.
    do_reset();
    any_mis = 1'b0;
    run_periods(300);
    apply(16'h0000, 1'b0);
    check_eq("saturate", bus.output__, 16'h48FF);
    check_eq("no_mis_300", {15'd0, any_mis}, 16'h0000);

    // Asynchronous reset between edges during RUN_Y.
    do_reset();
    for (int k = 0; k <= 10; k++) apply(legal_pair(k), 1'b0);
    check_eq("pre_async_y", bus.output__, 16'h8000);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst", bus.output__, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 11; k <= 14; k++) apply(legal_pair(k), 1'b0);
    check_eq("post_rst_sync", bus.output__, 16'h0000);
    apply(16'h0000, 1'b0);
    check_eq("post_rst_lock", bus.output__, 16'h4000);
    for (int k = 1; k <= 14; k++) apply(legal_pair(k), 1'b0);
    check_eq("post_rst_nowrap", bus.output__, 16'h4000);
    apply(16'h0000, 1'b0);
    check_eq("post_rst_wrap", bus.output__, 16'h4801);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e_counter_monitor.md
E_COUNTER_MONITOR -- requirements
Module: e_counter_monitor

Interface
REQ-001 Parameter X_MAX, default 8, terminal value of the x count phase; SHALL be in 1..255.
REQ-002 Parameter Y_MAX, default 6, terminal value of the y count phase; SHALL be in 1..255.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 input__  input  16  observed pair, packed {x[15:8], y[7:0]}, from the two-phase feedback counter.
REQ-006 clr_i  input  1  synchronous clear of sticky error and period count.
REQ-007 output__  output  16  packed {state[15:14], err_sticky[13], mismatch[12], wrap[11], 3'b000[10:8], periods[7:0]}.

Function
REQ-008 The block SHALL check the stream against the legal period: (0,0),(1,0)..(X_MAX,0),(X_MAX,1)..(X_MAX,Y_MAX), then (0,0) again; period length X_MAX+Y_MAX+1 cycles.
REQ-009 States SHALL be SYNC=2'd0, RUN_X=2'd1, RUN_Y=2'd2; 2'd3 unused, treated as SYNC.
REQ-010 Internal expected registers exp_x, exp_y (8 bit each) SHALL hold the pair expected on the next edge.
REQ-011 SYNC: input (0,0) -> RUN_X, exp=(1,0); any other input -> stay SYNC, no mismatch flagged.
REQ-012 RUN_X match with exp_x<X_MAX -> exp_x+1, stay RUN_X.
REQ-013 RUN_X match with exp_x==X_MAX -> RUN_Y, exp=(X_MAX,1).
REQ-014 RUN_Y match with exp_y<Y_MAX -> exp_y+1, stay RUN_Y.
REQ-015 RUN_Y match with exp_y==Y_MAX -> RUN_X, exp=(0,0), internal flag done=1.
REQ-016 RUN_X match of (0,0) with done=1 -> wrap pulse, periods+1 (saturating at 255), done=0, exp=(1,0).
REQ-017 Any mismatch in RUN_X/RUN_Y -> mismatch pulse, err_sticky=1, done=0; next state SYNC, except input (0,0) resyncs immediately to RUN_X, exp=(1,0), with no wrap.
REQ-018 mismatch, wrap, state, err_sticky, periods SHALL be registered: reflect the input sampled on the previous edge (latency 1 cycle).
REQ-019 mismatch and wrap SHALL be single-cycle pulses, never both 1 in one cycle.
REQ-020 clr_i=1 SHALL zero periods and err_sticky on the next edge; state/exp unaffected.
REQ-021 clr_i coincident with a mismatch: err_sticky SHALL be 1 and periods 0 after the edge.
REQ-022 clr_i coincident with wrap: periods SHALL be 0 (clear wins), wrap pulse still asserted.
REQ-023 Width rule: exp comparison is full 8-bit equality; increments never exceed parameter bounds, so no wrap-around of exp registers.

Reset
REQ-024 rst_i=1 SHALL immediately force state=SYNC, exp=(0,0), done=0, periods=0, err_sticky=0, mismatch=0, wrap=0, i.e. output__=16'h0000.
REQ-025 Reset asserted mid-period SHALL abandon the period; first edge after release re-enters SYNC logic on the sampled input.

Structure
REQ-026 State encoding constants and the output__ field bit positions SHALL live in the shared test package used by the counter benches.
REQ-027 A sub-module e_pair_expect (exp registers, equality compare, next-expected logic) SHALL be instantiated once; FSM, counters and flags remain in the top.

Verification
REQ-028 Reset, then drive legal sequence from e_counter (defaults) for 15 cycles -> no mismatch, wrap on cycle after 2nd (0,0), periods=1.
REQ-029 Drive 17 legal periods then clr_i for one cycle -> periods=0, err_sticky=0, state stays RUN_X.
REQ-030 In RUN_X force (5,0) where (4,0) expected -> mismatch pulse 1 cycle later, err_sticky=1, state=SYNC; next (0,0) -> RUN_X.
REQ-031 In RUN_Y force (0,0) at exp (8,3) -> mismatch=1, no wrap, state=RUN_X, following (1,0) accepted silently.
REQ-032 Run 300 legal periods -> periods saturates at 255, no mismatch.
REQ-033 Assert rst_i asynchronously between edges during RUN_Y -> output__=16'h0000 before next edge; after release legal stream resyncs, first wrap after full period.
